// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//
// Contents:
//   pc_sel_t - next-PC source encoding driven by the control FSM on `sel`
//              PC_SEL_INC (00) pc+1
//              PC_SEL_REG (01) register-file operand (sr1_out)
//              PC_SEL_REL (10) pc+offset
//              PC_SEL_VEC (11) trap/interrupt vector
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEL_INC = 2'b00,
        PC_SEL_REG = 2'b01,
        PC_SEL_REL = 2'b10,
        PC_SEL_VEC = 2'b11
    } pc_sel_t;

    localparam int unsigned PC_SEL_W = 2;

endpackage : pc_pkg

// File: rtl/pc_unit_ret_stack.sv
// ret_stack: circular return-address stack for the program-counter unit.
//
// The pointer `top` always addresses the most recently pushed entry. A push
// when full wraps the pointer and overwrites the oldest entry; the depth
// counter saturates at STACK_DEPTH and the sticky ovf flag is set. A pop when
// empty leaves the pointer alone and sets the sticky unf flag.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (pointer, depth, flags)
//   push   in   push wdata (already qualified by the caller's load enable)
//   pop    in   pop top entry (already qualified)
//   wdata  in   WIDTH  value to push / replace top with
//   rdata  out  WIDTH  current top entry (valid only when depth > 0)
//   depth  out  number of valid entries, 0..STACK_DEPTH
//   ovf    out  sticky: push while full
//   unf    out  sticky: pop while empty
module ret_stack #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [WIDTH-1:0]                   wdata,
    output logic [WIDTH-1:0]                   rdata,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               ovf,
    output logic                               unf
);

    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             empty;
    logic             full;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;

    // STACK_DEPTH is a power of two, so natural pointer overflow is the
    // modulo-STACK_DEPTH wrap.
    assign top_inc = top + PTR_W'(1);
    assign top_dec = top - PTR_W'(1);
    assign empty   = (depth == '0);
    assign full    = (depth == DEPTH_W'(STACK_DEPTH));
    assign rdata   = mem[top];

    // Write port: a push goes to the next slot; a push+pop with entries
    // present (tail call) rewrites the current top in place; a push+pop on
    // an empty stack is treated as a plain push.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = top_inc;
        if (push) begin
            mem_we = 1'b1;
            if (pop && !empty) begin
                mem_waddr = top;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top   <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    top <= top_inc;
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        depth <= depth + DEPTH_W'(1);
                    end
                end
                2'b01: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end else begin
                        top   <= top_dec;
                        depth <= depth - DEPTH_W'(1);
                    end
                end
                2'b11: begin
                    // Tail call never touches the flags.
                    if (empty) begin
                        top   <= top_inc;
                        depth <= DEPTH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : ret_stack

// File: rtl/pc_unit.sv
// pc_unit: program-counter register, next-PC selection and return stack.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (pc <= RESET_VEC, stack empty)
//   ld_pc     in   update pc and stack this edge; 0 holds everything
//   sel       in   next-PC source (pc_sel_t): pc+1 / sr1_out / pc+offset / vector
//   sr1_out   in   WIDTH  register operand (JMP target)
//   offset    in   WIDTH  pre-sign-extended PC-relative offset
//   vector    in   WIDTH  trap/interrupt target
//   push      in   call: save pc+1, jump to selected target
//   pop       in   return: pc <= top of stack (sel ignored)
//   pc        out  WIDTH  current PC (registered)
//   pc_plus1  out  WIDTH  pc+1, combinational from pc
//   depth     out  valid return-stack entries
//   ovf       out  sticky: push while stack full
//   unf       out  sticky: pop while stack empty
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VEC   = 16'h3000,
    parameter int unsigned      STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ld_pc,
    input  logic [PC_SEL_W-1:0]                sel,
    input  logic [WIDTH-1:0]                   sr1_out,
    input  logic [WIDTH-1:0]                   offset,
    input  logic [WIDTH-1:0]                   vector,
    input  logic                               push,
    input  logic                               pop,
    output logic [WIDTH-1:0]                   pc,
    output logic [WIDTH-1:0]                   pc_plus1,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               ovf,
    output logic                               unf
);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] stk_rdata;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_empty;

    // All sums wrap modulo 2^WIDTH.
    assign pc_plus1 = pc + WIDTH'(1);

    always_comb begin
        target = pc_plus1;
        case (pc_sel_t'(sel))
            PC_SEL_INC: target = pc_plus1;
            PC_SEL_REG: target = sr1_out;
            PC_SEL_REL: target = pc + offset;
            PC_SEL_VEC: target = vector;
            default:    target = pc_plus1;
        endcase
    end

    assign stk_push  = ld_pc & push;
    assign stk_pop   = ld_pc & pop;
    assign stk_empty = (depth == '0);

    // A lone pop returns to the stacked address, or falls through to pc+1
    // when the stack is empty. Push and push+pop both go to the target.
    always_comb begin
        pc_next = target;
        if (pop && !push) begin
            pc_next = stk_empty ? pc_plus1 : stk_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else if (ld_pc) begin
            pc <= pc_next;
        end
    end

    ret_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (pc_plus1),
        .rdata (stk_rdata),
        .depth (depth),
        .ovf   (ovf),
        .unf   (unf)
    );

endmodule : pc_unit
